// File: rtl/prog_counter.sv
// prog_counter
//   Fully synchronous WIDTH-bit counter with programmable terminal count,
//   up/down direction, synchronous clear and load, and wrap or saturate
//   behaviour at the limits. All outputs are registered on the single clk.
//
// Parameters
//   WIDTH      counter width in bits (>= 1)
//   MAX_VALUE  terminal count, range 0..MAX_VALUE (1..2**WIDTH-1)
//   SATURATE   0: wrap at the limits, 1: hold at the limits
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          count enable
//   up          direction, 1 = up, 0 = down
//   load        synchronous load of load_value (clamped to MAX_VALUE)
//   load_value  value to load
//   clear       synchronous clear to 0 (highest priority)
//   count       current count
//   toggle      one-cycle mask of the count bits changed by the last update
//   wrap        one-cycle pulse on a counting wrap (cascade enable)
//   at_limit    count is at the limit of the direction sampled last edge
module prog_counter #(
    parameter int WIDTH     = 5,
    parameter int MAX_VALUE = (1 << WIDTH) - 1,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] toggle,
    output logic             wrap,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    // Out-of-range loads clamp so the counter never leaves 0..MAX_VALUE.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    logic [WIDTH-1:0] next;
    logic             wrap_next;

    always_comb begin
        next      = count;
        wrap_next = 1'b0;
        if (clear) begin
            next = '0;
        end else if (load) begin
            next = clamp_load(load_value);
        end else if (en) begin
            if (up) begin
                if (count >= MAX_V) begin
                    if (!SATURATE) begin
                        next      = '0;
                        wrap_next = 1'b1;
                    end
                end else begin
                    next = count + ONE;
                end
            end else begin
                if (count == '0) begin
                    if (!SATURATE) begin
                        next      = MAX_V;
                        wrap_next = 1'b1;
                    end
                end else begin
                    next = count - ONE;
                end
            end
        end
    end

    // Output register stage: count, change mask, wrap pulse and the limit
    // flag decoded from the new count with the direction sampled this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            toggle   <= '0;
            wrap     <= 1'b0;
            at_limit <= 1'b0;
        end else begin
            count    <= next;
            toggle   <= count ^ next;
            wrap     <= wrap_next;
            at_limit <= up ? (next == MAX_V) : (next == '0);
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// Testbench for prog_counter: three WIDTH=5 variants (default, modulus 24,
// saturating) driven by shared stimulus, plus a two-stage WIDTH=2 cascade.
module tb_prog_counter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       up    = 1'b0;
    logic       load  = 1'b0;
    logic       clear = 1'b0;
    logic [4:0] lv    = 5'd0;
    logic       c_en  = 1'b0;

    logic [4:0] cnt_o [3];
    logic [4:0] tog_o [3];
    logic       wrap_o[3];
    logic       lim_o [3];
    logic [1:0] c_cnt [2];
    logic [1:0] c_tog [2];
    logic       c_wrap[2];
    logic       c_lim [2];

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    prog_counter #(.WIDTH(5)) u_dflt (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_value(lv),
        .clear(clear), .count(cnt_o[0]), .toggle(tog_o[0]), .wrap(wrap_o[0]), .at_limit(lim_o[0]));
    prog_counter #(.WIDTH(5), .MAX_VALUE(23)) u_m23 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_value(lv),
        .clear(clear), .count(cnt_o[1]), .toggle(tog_o[1]), .wrap(wrap_o[1]), .at_limit(lim_o[1]));
    prog_counter #(.WIDTH(5), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_value(lv),
        .clear(clear), .count(cnt_o[2]), .toggle(tog_o[2]), .wrap(wrap_o[2]), .at_limit(lim_o[2]));
    prog_counter #(.WIDTH(2)) u_c0 (
        .clk(clk), .rst_n(rst_n), .en(c_en), .up(1'b1), .load(1'b0), .load_value(2'b00),
        .clear(1'b0), .count(c_cnt[0]), .toggle(c_tog[0]), .wrap(c_wrap[0]), .at_limit(c_lim[0]));
    prog_counter #(.WIDTH(2)) u_c1 (
        .clk(clk), .rst_n(rst_n), .en(c_wrap[0]), .up(1'b1), .load(1'b0), .load_value(2'b00),
        .clear(1'b0), .count(c_cnt[1]), .toggle(c_tog[1]), .wrap(c_wrap[1]), .at_limit(c_lim[1]));

    // Behavioural model: index 0..2 are the WIDTH=5 variants, 3..4 the cascade.
    int m_max[5] = '{31, 23, 31, 3, 3};
    bit m_sat[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int m_cnt[5];
    int m_tog[5];
    bit m_wr [5];
    bit m_lim[5];

    task automatic model_update(input int k, input bit e, input bit u, input bit l,
                                input bit c, input int v);
        int nxt;
        bit wr;
        nxt = m_cnt[k];
        wr  = 1'b0;
        if (c) nxt = 0;
        else if (l) nxt = (v > m_max[k]) ? m_max[k] : v;
        else if (e && u) begin
            if (m_sat[k]) nxt = (m_cnt[k] + 1 > m_max[k]) ? m_max[k] : m_cnt[k] + 1;
            else begin
                nxt = (m_cnt[k] + 1) % (m_max[k] + 1);
                wr  = (m_cnt[k] == m_max[k]);
            end
        end else if (e && !u) begin
            if (m_sat[k]) nxt = (m_cnt[k] - 1 < 0) ? 0 : m_cnt[k] - 1;
            else begin
                nxt = (m_cnt[k] + m_max[k]) % (m_max[k] + 1);
                wr  = (m_cnt[k] == 0);
            end
        end
        m_tog[k] = m_cnt[k] ^ nxt;
        m_wr[k]  = wr;
        m_lim[k] = u ? (nxt == m_max[k]) : (nxt == 0);
        m_cnt[k] = nxt;
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit w0;
        if (!rst_n) begin
            for (int k = 0; k < 5; k++) begin
                m_cnt[k] = 0; m_tog[k] = 0; m_wr[k] = 1'b0; m_lim[k] = 1'b0;
            end
        end else begin
            w0 = m_wr[3];
            for (int k = 0; k < 3; k++) model_update(k, en, up, load, clear, int'(lv));
            model_update(3, c_en, 1'b1, 1'b0, 1'b0, 0);
            model_update(4, w0, 1'b1, 1'b0, 1'b0, 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("count[%0d]", k), int'(cnt_o[k]), m_cnt[k]);
                chk($sformatf("toggle[%0d]", k), int'(tog_o[k]), m_tog[k]);
                chk($sformatf("wrap[%0d]", k), int'(wrap_o[k]), int'(m_wr[k]));
                chk($sformatf("at_limit[%0d]", k), int'(lim_o[k]), int'(m_lim[k]));
            end
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("casc_count[%0d]", k), int'(c_cnt[k]), m_cnt[3+k]);
                chk($sformatf("casc_toggle[%0d]", k), int'(c_tog[k]), m_tog[3+k]);
                chk($sformatf("casc_wrap[%0d]", k), int'(c_wrap[k]), int'(m_wr[3+k]));
                chk($sformatf("casc_lim[%0d]", k), int'(c_lim[k]), int'(m_lim[3+k]));
            end
        end
    end

    task automatic step(input bit e, input bit u, input bit l, input bit c, input int v);
        en = e; up = u; load = l; clear = c; lv = v[4:0];
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        cmp_on = 1'b1;
        rst_n  = 1'b1;
        chk("rst_count", int'(cnt_o[0]), 0);
        chk("rst_toggle", int'(tog_o[0]), 0);
        chk("rst_wrap", int'(wrap_o[0]), 0);
        chk("rst_at_limit", int'(lim_o[0]), 0);

        // Reset mid-count
        for (int i = 0; i < 13; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk("mid_count13", int'(cnt_o[0]), 13);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(cnt_o[0]), 0);
        chk("async_rst_toggle", int'(tog_o[0]), 0);
        chk("async_rst_wrap", int'(wrap_o[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk("resume_count", int'(cnt_o[0]), 1);

        // Free-run up from 0
        step(1'b0, 1'b1, 1'b0, 1'b1, 0);
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 0);
            if (i == 16) begin
                chk("fr16_count", int'(cnt_o[0]), 16);
                chk("fr16_toggle", int'(tog_o[0]), 31);
            end
            if (i == 24) begin
                chk("m23_up_wrap_count", int'(cnt_o[1]), 0);
                chk("m23_up_wrap", int'(wrap_o[1]), 1);
            end
            if (i == 32) begin
                chk("fr32_count", int'(cnt_o[0]), 0);
                chk("fr32_wrap", int'(wrap_o[0]), 1);
                chk("fr32_toggle", int'(tog_o[0]), 31);
            end
            if (i == 33) chk("fr33_wrap", int'(wrap_o[0]), 0);
            if (i == 35) begin
                chk("sat_hold_count", int'(cnt_o[2]), 31);
                chk("sat_hold_toggle", int'(tog_o[2]), 0);
                chk("sat_hold_wrap", int'(wrap_o[2]), 0);
                chk("sat_hold_lim", int'(lim_o[2]), 1);
            end
        end
        chk("fr40_count", int'(cnt_o[0]), 8);
        chk("m23_40_count", int'(cnt_o[1]), 16);

        // Down from 0
        step(1'b0, 1'b0, 1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("m23_down_wrap_count", int'(cnt_o[1]), 23);
        chk("m23_down_wrap", int'(wrap_o[1]), 1);
        chk("dflt_down_wrap_count", int'(cnt_o[0]), 31);
        chk("sat_zero_count", int'(cnt_o[2]), 0);
        chk("sat_zero_wrap", int'(wrap_o[2]), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("m23_down_count", int'(cnt_o[1]), 22);

        // Saturate at top after load 30
        step(1'b0, 1'b1, 1'b1, 1'b0, 30);
        chk("sat_load30", int'(cnt_o[2]), 30);
        chk("m23_load_clamp", int'(cnt_o[1]), 23);
        for (int j = 1; j <= 4; j++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 0);
            if (j == 1) chk("sat_first_toggle", int'(tog_o[2]), 1);
            if (j >= 2) begin
                chk("sat_top_count", int'(cnt_o[2]), 31);
                chk("sat_top_toggle", int'(tog_o[2]), 0);
                chk("sat_top_wrap", int'(wrap_o[2]), 0);
            end
        end

        // Saturate at bottom after load 1
        step(1'b0, 1'b0, 1'b1, 1'b0, 1);
        for (int j = 1; j <= 3; j++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 0);
            chk("sat_bot_count", int'(cnt_o[2]), 0);
            if (j >= 2) begin
                chk("sat_bot_toggle", int'(tog_o[2]), 0);
                chk("sat_bot_wrap", int'(wrap_o[2]), 0);
            end
        end

        // Priority and clamp
        step(1'b1, 1'b1, 1'b1, 1'b1, 5);
        chk("prio_clear_m23", int'(cnt_o[1]), 0);
        chk("prio_clear_dflt", int'(cnt_o[0]), 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 29);
        chk("prio_load_m23", int'(cnt_o[1]), 23);
        chk("prio_load_wrap", int'(wrap_o[1]), 0);
        chk("prio_load_dflt", int'(cnt_o[0]), 29);

        // Direction change alone moves at_limit
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("lim_down_at23", int'(lim_o[1]), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("lim_up_at23", int'(lim_o[1]), 1);

        // Mixed directed vectors (model-checked)
        begin
            bit vec_e[10] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1};
            bit vec_u[10] = '{1, 0, 0, 1, 1, 1, 0, 0, 1, 0};
            bit vec_l[10] = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 0};
            bit vec_c[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
            int vec_v[10] = '{0, 0, 2, 0, 0, 31, 0, 0, 0, 0};
            for (int i = 0; i < 10; i++) step(vec_e[i], vec_u[i], vec_l[i], vec_c[i], vec_v[i]);
        end

        // Cascade
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        c_en = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 0);
            if (j == 4) begin
                chk("casc4_wrap0", int'(c_wrap[0]), 1);
                chk("casc4_count1", int'(c_cnt[1]), 0);
            end
            if (j == 5) begin
                chk("casc5_count1", int'(c_cnt[1]), 1);
                chk("casc5_toggle1", int'(c_tog[1]), 1);
            end
            if (j == 9) chk("casc9_count1", int'(c_cnt[1]), 2);
            if (j == 17) begin
                chk("casc17_count1", int'(c_cnt[1]), 0);
                chk("casc17_wrap1", int'(c_wrap[1]), 1);
            end
        end
        c_en = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
